// File: rtl/word_buff_pkg.sv
// Shared header for the word buffer and the processor blocks: default geometry,
// pointer-width helper and the per-cycle transfer encoding.
package word_buff_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    // Bits needed to address DEPTH entries (DEPTH is a power of two).
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Bit order is {push, pop} so the encoding can be built directly from the strobes.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } op_e;

endpackage

// File: rtl/word_buff_if.sv
// Producer/consumer handshake bundle of the word buffer; slave is the buffer side.
interface word_buff_if
    import word_buff_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
);

    logic                      in_valid;
    logic                      in_ready;
    logic                      in_repl;
    logic [WIDTH-1:0]          in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [WIDTH-1:0]          out_data;
    logic [ptr_width(DEPTH):0] count;

    modport master (
        output in_valid, in_repl, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_repl, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );

endinterface

// File: rtl/word_buff_mem.sv
// DEPTH x WIDTH storage array: synchronous write, asynchronous read, never cleared.
module word_buff_mem
    import word_buff_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW   = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write the addressed entry on an accepted push.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/word_buff.sv
// Small circular word FIFO with optional bit-0 replication on write and
// a zero-forced output whenever nothing is stored.
module word_buff
    import word_buff_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    word_buff_if.slave  bus
);

    localparam int AW = ptr_width(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             in_ready_s;
    logic             out_valid_s;
    logic             push_s;
    logic             pop_s;
    op_e              op_s;
    logic [WIDTH-1:0] word_s;
    logic [WIDTH-1:0] rd_word_s;
    logic [WIDTH-1:0] out_data_s;

    // Handshake flags depend only on the count register, never on out_ready.
    assign in_ready_s  = (count_r != FULL_COUNT);
    assign out_valid_s = (count_r != {CW{1'b0}});
    assign push_s      = bus.in_valid & in_ready_s;
    assign pop_s       = out_valid_s & bus.out_ready;
    assign op_s        = op_e'({push_s, pop_s});

    // Select the stored word: replicated bit 0 or the data as offered.
    always_comb begin
        word_s = bus.in_data;
        if (bus.in_repl) begin
            word_s = {WIDTH{bus.in_data[0]}};
        end else begin
            word_s = bus.in_data;
        end
    end

    // Pointer and occupancy state; flush outranks any transfer in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            case (op_s)
                OP_PUSH: begin
                    wr_ptr_r <= wr_ptr_r + AW'(1);
                    count_r  <= count_r + CW'(1);
                end
                OP_POP: begin
                    rd_ptr_r <= rd_ptr_r + AW'(1);
                    count_r  <= count_r - CW'(1);
                end
                OP_BOTH: begin
                    wr_ptr_r <= wr_ptr_r + AW'(1);
                    rd_ptr_r <= rd_ptr_r + AW'(1);
                end
                default: begin
                    wr_ptr_r <= wr_ptr_r;
                    rd_ptr_r <= rd_ptr_r;
                    count_r  <= count_r;
                end
            endcase
        end
    end

    word_buff_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push_s & ~flush),
        .waddr (wr_ptr_r),
        .wdata (word_s),
        .raddr (rd_ptr_r),
        .rdata (rd_word_s)
    );

    // Stale storage contents are masked while the buffer is empty.
    always_comb begin
        out_data_s = {WIDTH{1'b0}};
        if (out_valid_s) begin
            out_data_s = rd_word_s;
        end else begin
            out_data_s = {WIDTH{1'b0}};
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_data  = out_data_s;
    assign bus.count     = count_r;

endmodule
